// File: rtl/pll_reconfig_seq.sv
// Retunes a reconfigurable PLL: latches one request, writes the reconfig IP, polls status, then waits for a debounced lock.
// Avalon strobes are registered with one idle cycle between transfers; req_ready is low from acceptance until after the done pulse.
module pll_reconfig_seq #(
  parameter int NUM_OUTCLK     = 1,
  parameter int STATUS_TIMEOUT = 4096,
  parameter int LOCK_TIMEOUT   = 1000000,
  parameter int LOCK_STABLE    = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [17:0]              req_n,
  input  logic [17:0]              req_m,
  input  logic [NUM_OUTCLK*18-1:0] req_c,
  input  logic [3:0]               req_bw,
  input  logic [2:0]               req_cp,
  output logic                     done,
  output logic [1:0]               err,
  output logic                     busy,
  output logic                     locked_stable,
  output logic [5:0]               mgmt_address,
  output logic [31:0]              mgmt_writedata,
  output logic                     mgmt_write,
  output logic                     mgmt_read,
  input  logic [31:0]              mgmt_readdata,
  input  logic                     mgmt_waitrequest,
  input  logic                     pll_locked
);

  localparam int CW = $clog2(NUM_OUTCLK + 1);
  localparam int PW = $clog2(STATUS_TIMEOUT + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_STABLE + 1);

  localparam logic [CW-1:0] C_LAST     = CW'(NUM_OUTCLK - 1);
  localparam logic [PW-1:0] POLL_LAST  = PW'(STATUS_TIMEOUT - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [LW-1:0] STABLE_MAX = LW'(LOCK_STABLE);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_POLL = 3'd2;
  localparam logic [2:0] S_LOCK = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] ST_MODE = 3'd0;
  localparam logic [2:0] ST_N    = 3'd1;
  localparam logic [2:0] ST_M    = 3'd2;
  localparam logic [2:0] ST_C    = 3'd3;
  localparam logic [2:0] ST_BW   = 3'd4;
  localparam logic [2:0] ST_CP   = 3'd5;
  localparam logic [2:0] ST_GO   = 3'd6;

  logic [2:0]              state;
  logic [2:0]              step;
  logic [CW-1:0]           c_idx;
  logic [PW-1:0]           poll_cnt;
  logic [TW-1:0]           wait_cnt;
  logic [LW-1:0]           lock_cnt;
  logic [LW-1:0]           lock_cnt_nxt;
  logic [17:0]             n_q;
  logic [17:0]             m_q;
  logic [NUM_OUTCLK*18-1:0] c_q;
  logic [3:0]              bw_q;
  logic [2:0]              cp_q;
  logic [17:0]             c_sel;
  logic [5:0]              wr_addr;
  logic [31:0]             wr_data;
  logic                    wr_fin;
  logic                    rd_fin;
  logic                    start_done;
  logic                    unused_rdata;

  assign unused_rdata  = ^mgmt_readdata[31:1];
  assign wr_fin        = mgmt_write && !mgmt_waitrequest;
  assign rd_fin        = mgmt_read && !mgmt_waitrequest;
  assign start_done    = (state == S_WR) && wr_fin && (step == ST_GO);
  assign req_ready     = (state == S_IDLE);
  assign done          = (state == S_DONE);
  assign busy          = (state == S_WR) || (state == S_POLL) || (state == S_LOCK);
  assign locked_stable = (lock_cnt == STABLE_MAX);

  always_comb begin
    c_sel = '0;
    for (int k = 0; k < NUM_OUTCLK; k++) begin
      if (c_idx == CW'(k)) c_sel = c_q[k*18 +: 18];
    end
  end

  always_comb begin
    wr_addr = 6'd2;
    wr_data = 32'd0;
    case (step)
      ST_MODE: begin wr_addr = 6'd0; wr_data = 32'd1;                     end
      ST_N:    begin wr_addr = 6'd3; wr_data = {14'b0, n_q};              end
      ST_M:    begin wr_addr = 6'd4; wr_data = {14'b0, m_q};              end
      ST_C:    begin wr_addr = 6'd5; wr_data = {9'b0, 5'(c_idx), c_sel};  end
      ST_BW:   begin wr_addr = 6'd8; wr_data = {28'b0, bw_q};             end
      ST_CP:   begin wr_addr = 6'd9; wr_data = {29'b0, cp_q};             end
      default: begin wr_addr = 6'd2; wr_data = 32'd0;                     end
    endcase
  end

  // Start write clears the filter so a lock from the old frequency is never reported.
  always_comb begin
    if (start_done || !pll_locked)  lock_cnt_nxt = '0;
    else if (lock_cnt == STABLE_MAX) lock_cnt_nxt = lock_cnt;
    else                             lock_cnt_nxt = lock_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_cnt <= '0;
    else        lock_cnt <= lock_cnt_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      step           <= ST_MODE;
      c_idx          <= '0;
      poll_cnt       <= '0;
      wait_cnt       <= '0;
      err            <= 2'd0;
      n_q            <= '0;
      m_q            <= '0;
      c_q            <= '0;
      bw_q           <= '0;
      cp_q           <= '0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
      mgmt_write     <= 1'b0;
      mgmt_read      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            n_q   <= req_n;
            m_q   <= req_m;
            c_q   <= req_c;
            bw_q  <= req_bw;
            cp_q  <= req_cp;
            err   <= 2'd0;
            step  <= ST_MODE;
            c_idx <= '0;
            state <= S_WR;
          end
        end
        S_WR: begin
          if (mgmt_write) begin
            if (!mgmt_waitrequest) begin
              mgmt_write <= 1'b0;
              if (step == ST_GO) begin
                poll_cnt <= '0;
                state    <= S_POLL;
              end else if (step == ST_C && c_idx != C_LAST) begin
                c_idx <= c_idx + 1'b1;
              end else begin
                c_idx <= '0;
                step  <= step + 3'd1;
              end
            end
          end else begin
            mgmt_write     <= 1'b1;
            mgmt_address   <= wr_addr;
            mgmt_writedata <= wr_data;
          end
        end
        S_POLL: begin
          if (mgmt_read) begin
            if (rd_fin) begin
              mgmt_read <= 1'b0;
              if (mgmt_readdata[0]) begin
                wait_cnt <= '0;
                state    <= S_LOCK;
              end else begin
                poll_cnt <= poll_cnt + 1'b1;
                if (poll_cnt == POLL_LAST) begin
                  err   <= 2'd1;
                  state <= S_DONE;
                end
              end
            end
          end else begin
            mgmt_read      <= 1'b1;
            mgmt_address   <= 6'd1;
            mgmt_writedata <= 32'd0;
          end
        end
        S_LOCK: begin
          wait_cnt <= wait_cnt + 1'b1;
          // Lock success is checked first so it wins a tie with the timeout.
          if (lock_cnt_nxt == STABLE_MAX) begin
            err   <= 2'd0;
            state <= S_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            err   <= 2'd2;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
